sdu_uart_rx: RTL and testbench

Serial receive front end of the serial debug unit. Oversamples the asynchronous `rxd` pin 16× per bit, reassembles 8N1 frames (LSB first), and offers each byte to the debug command processor over a one-entry valid/ready buffer. Runs on the system clock with an internal baud-tick enable, so no divided clock leaves this block. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/sdu_uart_pkg.sv | 32 +++
 rtl/sdu_baud_tick.sv | 30 +++
 rtl/sdu_uart_rx.sv | 153 +++++++++++++++
 tb/tb_sdu_uart_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdu_uart_pkg.sv
// Shared definitions for the serial debug unit UART: state encoding,
// oversample constants, sample positions and the baud divisor helper.
// Pure declarations; no logic and no ports.
package sdu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  // Oversample factor is fixed; it is not a module parameter.
  localparam int unsigned OS = 16;

  // Oversample slots used for the three-sample majority vote.
  localparam logic [3:0] SAMP_A = 4'd7;
  localparam logic [3:0] SAMP_B = 4'd8;
  localparam logic [3:0] SAMP_C = 4'd9;

  // Baud-tick divisor: floor(clk_hz / (baud * OS)). Must come out >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * OS);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sdu_baud_tick.sv
// Oversample tick generator: free-running counter 0..DIV-1, one-cycle tick at DIV-1.
// Latency: tick is combinational from the count register.
// Backpressure: none; runs continuously after reset.
// Ports: clk (system clock), rst (sync active-high), tick (1-cycle enable).
module sdu_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sdu_uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority, one-entry output buffer.
// Latency: byte valid 1 cycle after the stop-bit decision tick; ferr/ovr likewise.
// Backpressure: vld/rdy buffer; a new byte while full and not accepted is dropped with ovr.
// Ports: clk, rst (sync active-high), rxd (async line, idles high),
//        d_rx/vld_rx/rdy_rx (byte handshake), ferr (bad stop bit), ovr (byte dropped).
module sdu_uart_rx
  import sdu_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] d_rx,
  output logic       vld_rx,
  input  logic       rdy_rx,
  output logic       ferr,
  output logic       ovr
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

  logic      rx_meta;
  logic      rxs;
  logic      tick;

  rx_state_t state, state_nxt;
  logic [3:0] os_cnt, os_nxt;
  logic [3:0] bit_idx, bit_nxt;   // counts to 8 so "all data bits taken" is visible
  logic [7:0] shreg, shreg_nxt;
  logic       samp_a, samp_a_nxt;
  logic       samp_b, samp_b_nxt;
  logic       bit_val;
  logic       deliver;
  logic       frame_err;

  // Two-flop synchronizer; resets to the idle line level so reset never
  // looks like a start edge by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  sdu_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Third sample is the live synchronized line on the decision tick.
  assign bit_val = maj3(samp_a, samp_b, rxs);

  always_comb begin
    state_nxt  = state;
    os_nxt     = os_cnt;
    bit_nxt    = bit_idx;
    shreg_nxt  = shreg;
    samp_a_nxt = samp_a;
    samp_b_nxt = samp_b;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    if (tick) begin
      if (state != IDLE) os_nxt = os_cnt + 4'd1;
      if (os_cnt == SAMP_A) samp_a_nxt = rxs;
      if (os_cnt == SAMP_B) samp_b_nxt = rxs;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            os_nxt    = 4'd0;
          end
        end
        START: begin
          if (os_cnt == SAMP_C) begin
            if (!bit_val) begin
              state_nxt = DATA;
              bit_nxt   = 4'd0;
            end else begin
              state_nxt = IDLE;   // glitch, silently ignored
            end
          end
        end
        DATA: begin
          if (os_cnt == SAMP_C && bit_idx != 4'd8) begin
            shreg_nxt = {bit_val, shreg[7:1]};   // LSB arrives first
            bit_nxt   = bit_idx + 4'd1;
          end else if (os_cnt == 4'd15 && bit_idx == 4'd8) begin
            state_nxt = STOP;
          end
        end
        STOP: begin
          // Good stop: return to IDLE mid-stop-bit so a back-to-back start
          // edge is not missed.
          if (os_cnt == SAMP_C) begin
            if (bit_val) begin
              deliver   = 1'b1;
              state_nxt = IDLE;
            end else begin
              frame_err = 1'b1;
              state_nxt = WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          if (rxs) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      os_cnt  <= 4'd0;
      bit_idx <= 4'd0;
      shreg   <= 8'd0;
      samp_a  <= 1'b0;
      samp_b  <= 1'b0;
      d_rx    <= 8'd0;
      vld_rx  <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      samp_a  <= samp_a_nxt;
      samp_b  <= samp_b_nxt;
      ferr    <= frame_err;
      ovr     <= 1'b0;
      if (deliver) begin
        // Same-cycle accept frees the slot, so the new byte replaces it.
        if (!vld_rx || rdy_rx) begin
          d_rx   <= shreg;
          vld_rx <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (vld_rx && rdy_rx) begin
        vld_rx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Self-checking bench for sdu_uart_rx at 1.6 MHz / 10 kbaud (DIV=10, 160 cycles per bit).
// Event-level scoreboard: frames are predicted as byte/ferr/ovr outcomes and
// matched against handshakes and pulses seen on the DUT outputs.
module tb_sdu_uart_rx;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 10_000;
  localparam int          BIT    = 160;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       rxd    = 1'b1;
  logic       rdy_rx = 1'b1;
  logic [7:0] d_rx;
  logic       vld_rx;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model state
  logic [7:0] exp_q[$];
  int         ferr_pend = 0;
  int         ovr_pend  = 0;
  bit         mdl_full  = 1'b0;

  // Observation state
  int         rise_cyc = 0;
  logic [7:0] last_acc = 8'd0;
  logic       prev_ok   = 1'b0;
  logic       prev_vld  = 1'b0;
  logic       prev_rdy  = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr  = 1'b0;
  logic [7:0] prev_d    = 8'd0;

  sdu_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .d_rx   (d_rx),
    .vld_rx (vld_rx),
    .rdy_rx (rdy_rx),
    .ferr   (ferr),
    .ovr    (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Advance n cycles, landing 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural one-entry buffer: what a completed frame must produce.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) ferr_pend++;
    else if (mdl_full && !rdy_rx) ovr_pend++;
    else begin
      exp_q.push_back(b);
      mdl_full = !rdy_rx;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bt,
                            input logic stop_v, input int stop_len);
    rxd = 1'b0;
    cyc(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(bt);
    end
    rxd = stop_v;
    cyc(bt * stop_len);
    rxd = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    cyc(20);
    while ((exp_q.size() != 0 || ferr_pend != 0 || ovr_pend != 0) && n < 5000) begin
      cyc(1);
      n++;
    end
    chk(exp_q.size() == 0, {name, "_bytes_left"}, exp_q.size(), 0);
    chk(ferr_pend == 0, {name, "_ferr_missing"}, ferr_pend, 0);
    chk(ovr_pend == 0, {name, "_ovr_missing"}, ovr_pend, 0);
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_ok   = 1'b0;
      prev_vld  = 1'b0;
      prev_ferr = 1'b0;
      prev_ovr  = 1'b0;
    end else begin
      if (prev_ok && prev_vld && !prev_rdy)
        chk(vld_rx && d_rx == prev_d, "hold_stable", {vld_rx, d_rx}, {1'b1, prev_d});
      if (vld_rx && rdy_rx) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", d_rx, 0);
        end else begin
          chk(d_rx == exp_q[0], "byte_value", d_rx, exp_q[0]);
          last_acc = d_rx;
          void'(exp_q.pop_front());
        end
      end
      if (vld_rx && !prev_vld) rise_cyc = cyc_n;
      if (ferr) begin
        chk(ferr_pend > 0, "unexpected_ferr", 1, 0);
        chk(!prev_ferr, "ferr_one_cycle", 1, 0);
        if (ferr_pend > 0) ferr_pend--;
      end
      if (ovr) begin
        chk(ovr_pend > 0, "unexpected_ovr", 1, 0);
        chk(!prev_ovr, "ovr_one_cycle", 1, 0);
        if (ovr_pend > 0) ovr_pend--;
      end
      prev_ok   = 1'b1;
      prev_vld  = vld_rx;
      prev_rdy  = rdy_rx;
      prev_ferr = ferr;
      prev_ovr  = ovr;
      prev_d    = d_rx;
    end
  end

  initial begin
    int c0;
    logic [7:0] b;

    // Reset state
    rst = 1'b1;
    cyc(3);
    chk(d_rx == 8'h00, "rst_d_rx", d_rx, 8'h00);
    chk(vld_rx == 1'b0, "rst_vld", vld_rx, 0);
    chk(ferr == 1'b0, "rst_ferr", ferr, 0);
    chk(ovr == 1'b0, "rst_ovr", ovr, 0);
    rst = 1'b0;
    cyc(50);

    // Single byte, consumer always ready
    model_frame(8'hA5, 1'b1);
    c0 = cyc_n;
    send_frame(8'hA5, BIT, 1'b1, 1);
    drain("single");
    chk(last_acc == 8'hA5, "single_literal", last_acc, 8'hA5);
    // Detection (3..12 cycles) + 154 ticks to the stop decision + register stage.
    chk(rise_cyc - c0 >= 1540 && rise_cyc - c0 <= 1556, "vld_latency", rise_cyc - c0, 1548);
    cyc(100);

    // Back-to-back with the consumer stalled: second byte dropped with ovr
    rdy_rx = 1'b0;
    model_frame(8'h00, 1'b1);
    send_frame(8'h00, BIT, 1'b1, 1);
    model_frame(8'hFF, 1'b1);
    send_frame(8'hFF, BIT, 1'b1, 1);
    cyc(20);
    chk(vld_rx == 1'b1, "stall_vld_held", vld_rx, 1);
    chk(d_rx == 8'h00, "stall_d_held", d_rx, 8'h00);
    rdy_rx   = 1'b1;
    mdl_full = 1'b0;
    drain("stall");
    chk(last_acc == 8'h00, "stall_literal", last_acc, 8'h00);
    cyc(100);

    // Framing error: stop held low for two bit times, then a clean frame
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, BIT, 1'b0, 2);
    drain("ferr");
    cyc(100);
    model_frame(8'h5A, 1'b1);
    send_frame(8'h5A, BIT, 1'b1, 1);
    drain("after_ferr");
    cyc(100);

    // Short low glitch on an idle line must produce nothing
    rxd = 1'b0;
    cyc(40);
    rxd = 1'b1;
    cyc(300);
    model_frame(8'h81, 1'b1);
    send_frame(8'h81, BIT, 1'b1, 1);
    drain("glitch");
    chk(last_acc == 8'h81, "glitch_literal", last_acc, 8'h81);
    cyc(100);

    // Baud skew +/-3%
    model_frame(8'h55, 1'b1);
    send_frame(8'h55, 165, 1'b1, 1);
    drain("skew_slow");
    cyc(100);
    model_frame(8'h55, 1'b1);
    send_frame(8'h55, 155, 1'b1, 1);
    drain("skew_fast");
    cyc(100);

    // Reset during bit 4 of 0xC3 (line is low there)
    b = 8'hC3;
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      cyc(BIT);
    end
    rxd = b[4];
    cyc(40);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    mdl_full = 1'b0;
    chk(vld_rx == 1'b0, "midrst_vld", vld_rx, 0);
    chk(d_rx == 8'h00, "midrst_d", d_rx, 8'h00);
    // The still-low line re-arms as a start bit; the tick phase restarts with
    // reset, so its bits land on the remainder of bit 4 (start), bit 5 (0),
    // bits 6/7, stop and idle (all 1): phantom byte 0xFE.
    model_frame(8'hFE, 1'b1);
    cyc(BIT - 41);
    for (int i = 5; i < 8; i++) begin
      rxd = b[i];
      cyc(BIT);
    end
    rxd = 1'b1;
    cyc(BIT);
    drain("midrst_phantom");
    cyc(200);
    model_frame(8'h12, 1'b1);
    send_frame(8'h12, BIT, 1'b1, 1);
    drain("after_rst");
    chk(last_acc == 8'h12, "after_rst_literal", last_acc, 8'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
